// File: rtl/gate_truth_checker_pkg.sv
// Shared types and truth-table constants for the gate truth checker.
// Each truth constant has bit i = expected gate output for input vector i.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } chk_state_t;

    localparam logic [1:0] TRUTH_NOT   = 2'b01;
    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
    localparam logic [3:0] TRUTH_NOR2  = 4'b0001;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_settle_counter.sv
// Loadable down-counter that times how long each stimulus vector is held.
// expired is high in the last DRIVE cycle, so the FSM moves to SAMPLE on that edge.
module settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps all input vectors of an N-input gate, waits SETTLE cycles per vector,
// then samples the gate output against TRUTH and accumulates pass/fail results.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int                          N_INPUTS = 2,
    parameter logic [(1<<N_INPUTS)-1:0]    TRUTH    = TRUTH_NOR2,
    parameter int                          SETTLE   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   dut_out,
    output logic [N_INPUTS-1:0]                    dut_in,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic [$clog2((1<<N_INPUTS)+1)-1:0]     err_count,
    output logic [N_INPUTS-1:0]                    first_fail,
    output logic                                   first_fail_valid
);

    localparam int NV = 1 << N_INPUTS;
    localparam int EW = $clog2(NV + 1);

    chk_state_t    state, state_next;
    logic          start_go;
    logic          last_vec;
    logic          mismatch;
    logic          expired;
    logic [EW-1:0] err_next;

    // dut_in doubles as the vector register, so the stimulus is held through SAMPLE.
    assign start_go = ((state == IDLE) || (state == DONE)) && start;
    assign last_vec = (dut_in == N_INPUTS'(NV - 1));
    assign mismatch = (state == SAMPLE) && (dut_out != TRUTH[dut_in]);
    assign err_next = err_count + EW'(mismatch);

    settle_counter #(.SETTLE(SETTLE)) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (start_go || (state == SAMPLE && !last_vec)),
        .en      (state == DRIVE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start)   state_next = DRIVE;
            DRIVE:      if (expired) state_next = SAMPLE;
            SAMPLE:     state_next = last_vec ? DONE : DRIVE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_go) begin
                dut_in           <= '0;
                err_count        <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
                busy             <= 1'b1;
            end else if (state == SAMPLE) begin
                err_count <= err_next;
                if (mismatch && !first_fail_valid) begin
                    first_fail       <= dut_in;
                    first_fail_valid <= 1'b1;
                end
                if (last_vec) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_next == '0);
                end else begin
                    dut_in <= dut_in + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: two checkers (SETTLE=1 and SETTLE=3)
// driving selectable gate models, checked every cycle against a cycle-count model.
module tb_gate_truth_checker;
    import gate_check_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           start;
    logic [1:0]           gout;
    logic [1:0][1:0]      din;
    logic [1:0]           busy, done, pass, ffv;
    logic [1:0][2:0]      errc;
    logic [1:0][1:0]      ff;
    logic [1:0]           lag1 = 2'b11;
    logic [1:0]           lag2 = 2'b11;
    int                   mode [2];
    bit                   armed = 1'b0;
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    gate_truth_checker #(.N_INPUTS(2), .TRUTH(TRUTH_NOR2), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .dut_out(gout[0]), .dut_in(din[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_fail(ff[0]), .first_fail_valid(ffv[0])
    );

    gate_truth_checker #(.N_INPUTS(2), .TRUTH(TRUTH_NOR2), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .dut_out(gout[1]), .dut_in(din[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_fail(ff[1]), .first_fail_valid(ffv[1])
    );

    // Gate models: 0 NOR, 1 stuck-at-1, 2 stuck-at-0, 3 NOR lagging by two cycles.
    always_comb begin
        gout = '0;
        for (int i = 0; i < 2; i++) begin
            case (mode[i])
                0:       gout[i] = ~|din[i];
                1:       gout[i] = 1'b1;
                2:       gout[i] = 1'b0;
                default: gout[i] = lag2[i];
            endcase
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            lag1[i] <= ~|din[i];
            lag2[i] <= lag1[i];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts cycles since the start edge; vector = k/(SETTLE+1),
    // sample at the edge closing every (SETTLE+1)-th cycle, done at k = 4*(SETTLE+1).
    int  mk   [2];
    bit  msw  [2];
    bit  mdone[2];
    bit  mpass[2];
    bit  mffv [2];
    int  merr [2];
    int  mff  [2];
    int  hist [2][3];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0; msw[i] = 0; mdone[i] = 0; mpass[i] = 0; mffv[i] = 0;
            merr[i] = 0; mff[i] = 0;
            for (int j = 0; j < 3; j++) hist[i][j] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int s, tot, nd, v, obs;
            logic [3:0] tt;
            tt  = TRUTH_NOR2;
            s   = (i == 0) ? 1 : 3;
            tot = 4 * (s + 1);
            nd  = hist[i][0];
            if (rst) begin
                msw[i] = 0; mdone[i] = 0; mpass[i] = 0; mffv[i] = 0;
                merr[i] = 0; mff[i] = 0; mk[i] = 0; nd = 0;
            end else if (!msw[i] && start[i]) begin
                msw[i] = 1; mk[i] = 0; merr[i] = 0; mffv[i] = 0; mpass[i] = 0;
                mdone[i] = 0; nd = 0;
            end else if (msw[i]) begin
                if ((mk[i] + 1) % (s + 1) == 0) begin
                    v = mk[i] / (s + 1);
                    case (mode[i])
                        0:       obs = (hist[i][0] == 0) ? 1 : 0;
                        1:       obs = 1;
                        2:       obs = 0;
                        default: obs = (hist[i][2] == 0) ? 1 : 0;
                    endcase
                    if (obs != int'(tt[v])) begin
                        merr[i]++;
                        if (!mffv[i]) begin
                            mff[i]  = v;
                            mffv[i] = 1;
                        end
                    end
                end
                mk[i]++;
                if (mk[i] == tot) begin
                    msw[i]   = 0;
                    mdone[i] = 1;
                    mpass[i] = (merr[i] == 0);
                end else begin
                    nd = mk[i] / (s + 1);
                end
            end else begin
                mdone[i] = 0;
            end
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = nd;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i),  int'(busy[i]), int'(msw[i]));
                chk($sformatf("done[%0d]", i),  int'(done[i]), int'(mdone[i]));
                chk($sformatf("pass[%0d]", i),  int'(pass[i]), int'(mpass[i]));
                chk($sformatf("err[%0d]", i),   int'(errc[i]), merr[i]);
                chk($sformatf("ffv[%0d]", i),   int'(ffv[i]),  int'(mffv[i]));
                chk($sformatf("ff[%0d]", i),    int'(ff[i]),   mff[i]);
                chk($sformatf("din[%0d]", i),   int'(din[i]),  hist[i][0]);
            end
        end
    end

    // Pulse start, then count cycles until done; restart_at re-raises start mid-sweep.
    task automatic sweep(input int i, input int exp_cyc, input int restart_at);
        int cnt;
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        cnt = 0;
        while (cnt < 200 && !done[i]) begin
            start[i] = (cnt == restart_at);
            @(negedge clk);
            cnt++;
        end
        start[i] = 1'b0;
        chk($sformatf("done_cycle[%0d]", i), cnt, exp_cyc);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        start = '0;
        mode[0] = 0;
        mode[1] = 0;
        @(posedge clk);
        armed = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_din",  int'(din[0]),  0);
        chk("reset_err",  int'(errc[0]), 0);
        rst = 1'b0;

        // NOR2 pass
        sweep(0, 8, -1);
        chk("nor_pass", int'(pass[0]), 1);
        chk("nor_err",  int'(errc[0]), 0);
        chk("nor_ffv",  int'(ffv[0]),  0);
        chk("nor_din_last", int'(din[0]), 3);
        @(negedge clk) chk("nor_done_width", int'(done[0]), 0);

        // Stuck-at-1
        mode[0] = 1;
        sweep(0, 8, -1);
        chk("s1_err",  int'(errc[0]), 3);
        chk("s1_ff",   int'(ff[0]),   1);
        chk("s1_ffv",  int'(ffv[0]),  1);
        chk("s1_pass", int'(pass[0]), 0);

        // Stuck-at-0
        mode[0] = 2;
        sweep(0, 8, -1);
        chk("s0_err",  int'(errc[0]), 1);
        chk("s0_ff",   int'(ff[0]),   0);
        chk("s0_pass", int'(pass[0]), 0);

        // Lagging gate: long settle passes, short settle fails
        mode[1] = 3;
        sweep(1, 16, -1);
        chk("lag_s3_pass", int'(pass[1]), 1);
        mode[0] = 3;
        sweep(0, 8, -1);
        chk("lag_s1_pass", int'(pass[0]), 0);
        chk("lag_s1_ffv",  int'(ffv[0]),  1);

        // Start while busy, re-asserted so it is sampled at edge 4
        mode[0] = 0;
        sweep(0, 8, 3);
        chk("rebusy_pass", int'(pass[0]), 1);
        chk("rebusy_err",  int'(errc[0]), 0);

        // Reset mid-sweep, sampled at edge 5
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy[0]), 0);
        chk("mid_rst_din",  int'(din[0]),  0);
        chk("mid_rst_err",  int'(errc[0]), 0);
        chk("mid_rst_ffv",  int'(ffv[0]),  0);
        chk("mid_rst_ff",   int'(ff[0]),   0);
        chk("mid_rst_pass", int'(pass[0]), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done[0]) seen = 1;
        end
        chk("mid_rst_no_done", seen, 0);
        sweep(0, 8, -1);
        chk("post_rst_pass", int'(pass[0]), 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
